// File: rtl/mod_mult_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mod_mult_arbiter: shares one (a*b) mod Q multiplier among NUM_REQ          |
// | requesters. Round-robin when MOD_MULT_ARB_RR_EN is defined, else fixed.    |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module mod_mult_arbiter #(
  parameter int WIDTH   = 32,
  parameter int Q       = 3329,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  localparam int               PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2*WIDTH-1:0] Q_W = (2*WIDTH)'(Q);

  logic [NUM_REQ-1:0] grant;
  logic               grant_found;
  logic               handshake;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

`ifdef MOD_MULT_ARB_RR_EN
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;

  // Two passes: first the requesters at or above ptr, then wrap to the rest.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (PTR_W'(i) >= ptr)) begin
        grant[i]    = 1'b1;
        grant_idx   = PTR_W'(i);
        grant_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant[i]    = 1'b1;
        grant_idx   = PTR_W'(i);
        grant_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (handshake) begin
      ptr <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant[i]    = 1'b1;
        grant_found = 1'b1;
      end
    end
  end
`endif

  assign req_ready = (en && !rst) ? grant : '0;
  assign handshake = |req_ready;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  logic                s1_valid;
  logic [NUM_REQ-1:0]  s1_tag;
  logic [WIDTH-1:0]    s1_a;
  logic [WIDTH-1:0]    s1_b;

  // Operands only load on a handshake, so the multiplier output is stable otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= handshake;
      if (handshake) begin
        s1_tag <= req_ready;
        s1_a   <= sel_a;
        s1_b   <= sel_b;
      end
    end
  end

  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mult_res;

  assign product  = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
  assign mult_res = WIDTH'(product % Q_W);

  generate
    if (LATENCY == 1) begin : g_lat1
      assign rsp_valid = s1_valid ? s1_tag : '0;
      assign rsp_data  = mult_res;
      assign busy      = s1_valid;
    end else begin : g_latn
      localparam int DEPTH = LATENCY - 1;
      logic [DEPTH-1:0]   d_valid;
      logic [NUM_REQ-1:0] d_tag  [DEPTH];
      logic [WIDTH-1:0]   d_data [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d_valid <= '0;
          for (int k = 0; k < DEPTH; k++) begin
            d_tag[k]  <= '0;
            d_data[k] <= '0;
          end
        end else begin
          d_valid[0] <= s1_valid;
          if (s1_valid) begin
            d_tag[0]  <= s1_tag;
            d_data[0] <= mult_res;
          end
          for (int k = 1; k < DEPTH; k++) begin
            d_valid[k] <= d_valid[k-1];
            if (d_valid[k-1]) begin
              d_tag[k]  <= d_tag[k-1];
              d_data[k] <= d_data[k-1];
            end
          end
        end
      end

      assign rsp_valid = d_valid[DEPTH-1] ? d_tag[DEPTH-1] : '0;
      assign rsp_data  = d_data[DEPTH-1];
      assign busy      = s1_valid | (|d_valid);
    end
  endgenerate

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_grant_valid:  assert property (@(posedge clk) disable iff (rst) ((req_ready & ~req_valid) == '0));

endmodule
`default_nettype wire

// File: tb/tb_mod_mult_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mod_mult_arbiter: scoreboard bench for mod_mult_arbiter.                |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_mod_mult_arbiter;

  localparam int WIDTH   = 32;
  localparam int Q       = 3329;
  localparam int NUM_REQ = 4;
  localparam int LATENCY = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic         busy;

  always #5 clk = ~clk;

  mod_mult_arbiter #(
    .WIDTH(WIDTH), .Q(Q), .NUM_REQ(NUM_REQ), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy)
  );

  typedef struct {
    int unsigned cyc;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          model_ptr = 0;
  logic [31:0] op_d [4];
  logic [31:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return 32'(p % 64'd3329);
  endfunction

  function automatic logic [3:0] model_grant(input logic [3:0] v, input logic e, input int p);
    int i;
    if (!e) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      i = (p + k) % 4;
      if (v[i]) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    op_d[i] = d;
  endtask

  task automatic rand_op(input int i);
    logic [31:0] a, b;
    a = $urandom;
    b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 4000)) : $urandom;
    set_op(i, a, b, golden(a, b));
  endtask

  // Response monitor: pops the scoreboard whenever the DUT emits a result.
  always @(negedge clk) begin
    if (rst) begin
      last_data = '0;
    end else if (rsp_valid !== 4'b0000) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected cyc=%0d: rsp_valid=%b data=%0d, required no response", cyc, rsp_valid, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || rsp_valid !== mon_e.tag || rsp_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL rsp cyc=%0d: tag=%b data=%0d, required cyc=%0d tag=%b data=%0d",
                   cyc, rsp_valid, rsp_data, mon_e.cyc, mon_e.tag, mon_e.data);
        end
      end
      last_data = rsp_data;
    end else begin
      n_tests++;
      if (rsp_data !== last_data) begin
        n_fail++;
        $display("FAIL rsp_hold cyc=%0d: rsp_data=%0d, required %0d", cyc, rsp_data, last_data);
      end
      if (sb.size() != 0) begin
        n_tests++;
        if (sb[0].cyc <= cyc) begin
          n_fail++;
          $display("FAIL rsp_missing cyc=%0d: rsp_valid=0, required tag=%b data=%0d", cyc, sb[0].tag, sb[0].data);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at the following posedge+1.
  task automatic drive_cycle(input logic [3:0] v, input logic e);
    logic [3:0] exp_rdy;
    exp_t       x;
    int         g;
    req_valid = v;
    en = e;
    #1;
    exp_rdy = model_grant(v, e, model_ptr);
    n_tests++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL grant cyc=%0d: req_ready=%b, required %b", cyc, req_ready, exp_rdy);
    end
    g = -1;
    for (int i = 0; i < 4; i++) if (exp_rdy[i]) g = i;
    if (g >= 0) begin
      x.cyc  = cyc + LATENCY;
      x.tag  = exp_rdy;
      x.data = op_d[g];
      sb.push_back(x);
`ifdef MOD_MULT_ARB_RR_EN
      model_ptr = (g + 1) % 4;
`endif
    end
    @(posedge clk);
    #1;
    if (g >= 0) rand_op(g);
  endtask

  task automatic drain;
    int n;
    n = 0;
    req_valid = '0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    en = 1'b1;
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_data !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b rsp_valid=%b data=%0d busy=%b, required 0 0 0 0",
               req_ready, rsp_valid, rsp_data, busy);
    end
    req_valid = '0;
    rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < 4; i++) rand_op(i);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 6; k++) drive_cycle(4'b1111, 1'b1);
    drain();
  endtask

  task automatic test_single;
    set_op(2, 32'd2000, 32'd3000, 32'd1142);
    drive_cycle(4'b0100, 1'b1);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_t1: busy=%b, required 1", busy); end
    drive_cycle(4'b0000, 1'b1);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_t2: busy=%b, required 1", busy); end
    drive_cycle(4'b0000, 1'b1);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_t3: busy=%b, required 0", busy); end
    drain();
  endtask

  task automatic test_edges;
    set_op(0, 32'd3328, 32'd3328, 32'd1);
    drive_cycle(4'b0001, 1'b1);
    set_op(0, 32'd3329, 32'd5, 32'd0);
    drive_cycle(4'b0001, 1'b1);
    set_op(0, 32'hFFFF_FFFF, 32'd1, 32'd1352);
    drive_cycle(4'b0001, 1'b1);
    set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd283);
    drive_cycle(4'b0010, 1'b1);
    drain();
  endtask

  task automatic test_en;
    drive_cycle(4'b1111, 1'b1);
    drive_cycle(4'b1111, 1'b1);
    for (int k = 0; k < 3; k++) drive_cycle(4'b1111, 1'b0);
    drive_cycle(4'b1111, 1'b1);
    drive_cycle(4'b1111, 1'b1);
    drain();
  endtask

  task automatic test_wrap;
    drive_cycle(4'b1000, 1'b1);
    drive_cycle(4'b0010, 1'b1);
    drain();
  endtask

  task automatic test_rst_inflight;
    drive_cycle(4'b0010, 1'b1);
    drive_cycle(4'b0100, 1'b1);
    rst = 1'b1;
    sb.delete();
    req_valid = 4'b1111;
    en = 1'b1;
    #1;
    n_tests++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_data !== 32'd0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_inflight: rsp_valid=%b busy=%b data=%0d ready=%b, required 0 0 0 0",
               rsp_valid, busy, rsp_data, req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_ptr = 0;
    req_valid = '0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_rst: busy=%b, required 0", busy); end
    #1;
    n_tests++;
    req_valid = 4'b1110;
    #1;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL grant_after_rst_partial: req_ready=%b, required 0010", req_ready);
    end
    @(posedge clk);
    #1;
    sb.delete();
    model_ptr = 0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    drive_cycle(4'b1111, 1'b1);
    drain();
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++)
      drive_cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_edges();
    test_en();
    test_wrap();
    test_rst_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
